// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide FWFT FIFO feeding the UART transmitter, with level, low-watermark irq, sticky overflow and flush.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    output logic          o_full,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [7:0]    o_data,
    output logic          o_empty,
    output logic [AW:0]   o_level,
    input  logic [AW:0]   i_threshold,
    output logic          o_threshold_irq,
    output logic          o_overflow,
    input  logic          i_overflow_clr
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop, ovf_set;

    // Pointers carry one extra bit, so their difference is the fill level 0..DEPTH.
    assign o_level         = wr_ptr - rd_ptr;
    assign o_empty         = wr_ptr == rd_ptr;
    assign o_full          = o_level == (AW+1)'(DEPTH);
    assign o_valid         = !o_empty;
    assign o_data          = mem[rd_ptr[AW-1:0]];
    assign o_threshold_irq = o_level <= i_threshold;
    assign pop             = o_valid && i_ready;
    assign push            = i_wr_en && (!o_full || pop);
    assign ovf_set         = i_wr_en && o_full && !pop && !i_flush;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
            o_overflow <= ovf_set || (o_overflow && !i_overflow_clr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vector table plus hand sequences for fill/overflow, wrap-around, flush and async reset.
module tb_uart_tx_fifo;
    logic       i_clk = 1'b0;
    logic       i_nrst, i_flush, i_wr_en, i_ready, i_overflow_clr;
    logic [7:0] i_wr_data, o_data;
    logic [4:0] i_threshold, o_level;
    logic       o_full, o_valid, o_empty, o_threshold_irq, o_overflow;
    int         checks = 0;
    int         errors = 0;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .o_full(o_full), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_empty(o_empty), .o_level(o_level), .i_threshold(i_threshold),
        .o_threshold_irq(o_threshold_irq), .o_overflow(o_overflow), .i_overflow_clr(i_overflow_clr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       f, w;
        logic [7:0] d;
        logic       r, c;
        logic [4:0] thr;
        logic [4:0] lvl;
        logic       vld, emp, ful, irq, ovf;
        logic [7:0] dout;
    } vec_t;

    vec_t tv[19];

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_state(input logic [4:0] lvl, input logic vld, emp, ful, irq, ovf);
        chk("level", 8'(o_level), 8'(lvl));
        chk("valid", 8'(o_valid), 8'(vld));
        chk("empty", 8'(o_empty), 8'(emp));
        chk("full", 8'(o_full), 8'(ful));
        chk("irq", 8'(o_threshold_irq), 8'(irq));
        chk("overflow", 8'(o_overflow), 8'(ovf));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, showing state from the previous rising edge.
    task automatic drive(input logic f, w, input logic [7:0] d, input logic r, c);
        @(negedge i_clk);
        i_flush = f;
        i_wr_en = w;
        i_wr_data = d;
        i_ready = r;
        i_overflow_clr = c;
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        tv[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        tv[3]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        tv[7]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[8]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
        tv[9]  = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
        tv[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tv[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        tv[13] = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66};
        tv[14] = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        tv[15] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        tv[16] = '{1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        tv[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        i_nrst = 1'b0;
        i_flush = 1'b0;
        i_wr_en = 1'b0;
        i_wr_data = 8'h00;
        i_ready = 1'b0;
        i_overflow_clr = 1'b0;
        i_threshold = 5'd2;
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            i_threshold = tv[i].thr;
            drive(tv[i].f, tv[i].w, tv[i].d, tv[i].r, tv[i].c);
            chk_state(tv[i].lvl, tv[i].vld, tv[i].emp, tv[i].ful, tv[i].irq, tv[i].ovf);
            if (tv[i].vld) chk("data", o_data, tv[i].dout);
        end
        // Fill to full, overflow, set-wins-over-clear, then full write+pop.
        i_threshold = 5'd16;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk_state(5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
        chk_state(5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_state(5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk_state(5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("full_head", o_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_level", 8'(o_level), 8'(16 - i));
            chk("drain_data", o_data, i < 15 ? 8'(i + 1) : 8'h55);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_state(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // Wrap-around: alternating write and read bursts of 8 bytes against a queue model.
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 8; j++) begin
                b = 8'(k * 19 + j * 7 + 3);
                drive(1'b0, k % 2 == 0, b, k % 2 == 1, 1'b0);
                chk("wrap_level", 8'(o_level), 8'(q.size()));
                if (k % 2 == 1) chk("wrap_data", o_data, q.pop_front());
                if (k % 2 == 0) q.push_back(b);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_empty", 8'(o_empty), 8'd1);
        // Flush with overflow pending: level clears, overflow survives.
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
        chk_state(5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_state(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        // Asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_data", o_data, 8'h01);
        @(negedge i_clk);
        #2 i_nrst = 1'b0;
        #1;
        chk_state(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_nrst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_state(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
